// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store types: memory-op encoding (funct3), LSU FSM states and
// the helper that flags op/direction combinations the LSU refuses to issue.
package rv32i_pkg;

    typedef enum logic [2:0] {
        MemB  = 3'd0,
        MemH  = 3'd1,
        MemW  = 3'd2,
        MemBU = 3'd4,
        MemHU = 3'd5
    } mem_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } lsu_state_e;

    // Unsigned variants only make sense for loads.
    function automatic logic op_illegal(logic [2:0] op, logic we);
        logic bad;
        bad = (op == 3'd3) || (op == 3'd6) || (op == 3'd7);
        if (we && (op == MemBU || op == MemHU)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data replication and byte strobes, plus load
// lane selection with sign/zero extension for the registered access.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic        we_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        mem_wdata_o = wdata_i;
        mem_wstrb_o = '0;
        load_data_o = '0;
        byte_sel    = mem_rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel    = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (op_i)
            MemB: begin
                mem_wdata_o = {4{wdata_i[7:0]}};
                mem_wstrb_o = 4'b0001 << addr_lo_i;
                load_data_o = {{24{byte_sel[7]}}, byte_sel};
            end
            MemH: begin
                mem_wdata_o = {2{wdata_i[15:0]}};
                mem_wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                load_data_o = {{16{half_sel[15]}}, half_sel};
            end
            MemW: begin
                mem_wstrb_o = 4'b1111;
                load_data_o = mem_rdata_i;
            end
            MemBU:   load_data_o = {24'd0, byte_sel};
            MemHU:   load_data_o = {16'd0, half_sel};
            default: ;
        endcase
        if (we_i) begin
            load_data_o = '0;
        end else begin
            mem_wstrb_o = '0;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE -> ACCESS -> RESP handshake with a bounded memory wait.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned H/W accesses into error responses.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_op,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_rsp_valid,
    output logic [XLEN-1:0]   o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_stall,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN/8-1:0] o_mem_wstrb,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [XLEN-1:0]   i_mem_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              req_bad;
    logic [XLEN-1:0]   addr_fix;
    logic [XLEN-1:0]   align_wdata;
    logic [XLEN-1:0]   load_data;
    logic [XLEN/8-1:0] align_wstrb;

    lsu_align u_align (
        .op_i        (op_q),
        .we_i        (we_q),
        .addr_lo_i   (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .mem_rdata_i (i_mem_rdata),
        .mem_wdata_o (align_wdata),
        .mem_wstrb_o (align_wstrb),
        .load_data_o (load_data)
    );

    always_comb begin
        addr_fix = i_req_addr;
        req_bad  = op_illegal(i_req_op, i_req_we);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((i_req_op == MemH || i_req_op == MemHU) && i_req_addr[0]) begin
            req_bad = 1'b1;
        end
        if (i_req_op == MemW && i_req_addr[1:0] != 2'b00) begin
            req_bad = 1'b1;
        end
`else
        // Misaligned accesses are silently forced onto their natural boundary.
        if (i_req_op == MemH || i_req_op == MemHU) begin
            addr_fix[0] = 1'b0;
        end
        if (i_req_op == MemW) begin
            addr_fix[1:0] = 2'b00;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    op_d    = i_req_op;
                    addr_d  = addr_fix;
                    wdata_d = i_req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = req_bad;
                    state_d = req_bad ? StResp : StAccess;
                end
            end
            StAccess: begin
                // An ack on the expiry cycle still completes normally.
                if (i_mem_ack) begin
                    rdata_d = load_data;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        i_req_ready = (state_q == StIdle);
        o_stall     = ((state_q == StIdle) && i_req_valid) || (state_q == StAccess);
        o_mem_req   = (state_q == StAccess);
        o_mem_we    = o_mem_req && we_q;
        o_mem_addr  = o_mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
        o_mem_wstrb = o_mem_req ? align_wstrb : '0;
        o_mem_wdata = o_mem_req ? align_wdata : '0;
        o_rsp_valid = (state_q == StResp);
        o_rsp_err   = o_rsp_valid && err_q;
        o_rsp_rdata = o_rsp_valid ? rdata_q : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: expected responses are queued when a request
// is driven and matched when o_rsp_valid fires; a small in-bench memory supplies acks.
module tb_load_store_unit;

    logic        i_clk;
    logic        i_rst;
    logic        i_req_valid;
    logic        i_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_op;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_stall;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_wstrb;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_rsp_t;

    exp_rsp_t sb_q[$];
    int       n_checks;
    int       n_errors;

    load_store_unit #(
        .XLEN    (32),
        .TIMEOUT (16)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_ready (i_req_ready),
        .i_req_we    (i_req_we),
        .i_req_op    (i_req_op),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_stall     (o_stall),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wstrb (o_mem_wstrb),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drives one request, plays memory for it and checks the response against the queue.
    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int waits, input logic [31:0] word,
                          input logic exp_mem, input logic [31:0] exp_maddr,
                          input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        exp_rsp_t e;
        exp_rsp_t got;
        int       cyc;
        int       acc;
        logic     done;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_op    = op;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        #1;
        check("req_ready", {31'd0, i_req_ready}, 32'd1);
        check("stall_req", {31'd0, o_stall}, 32'd1);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sb_q.push_back(e);
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        cyc  = 1;
        acc  = 0;
        done = 1'b0;
        while (!done && cyc <= 40) begin
            if (o_rsp_valid) begin
                got = sb_q.pop_front();
                check("rsp_rdata", o_rsp_rdata, got.rdata);
                check("rsp_err", {31'd0, o_rsp_err}, {31'd0, got.err});
                check("rsp_latency", cyc, got.lat);
                check("mem_req_in_resp", {31'd0, o_mem_req}, 32'd0);
                check("stall_in_resp", {31'd0, o_stall}, 32'd0);
                i_mem_ack = 1'b0;
                done = 1'b1;
            end else begin
                check("mem_req", {31'd0, o_mem_req}, {31'd0, exp_mem});
                if (o_mem_req) begin
                    acc++;
                    check("mem_addr", o_mem_addr, exp_maddr);
                    check("mem_wstrb", {28'd0, o_mem_wstrb}, {28'd0, exp_wstrb});
                    check("mem_we", {31'd0, o_mem_we}, {31'd0, we});
                    check("stall_access", {31'd0, o_stall}, 32'd1);
                    if (we) check("mem_wdata", o_mem_wdata, exp_wdata);
                    i_mem_ack   = (acc == waits + 1);
                    i_mem_rdata = word;
                end else begin
                    i_mem_ack = 1'b0;
                end
                step();
                cyc++;
            end
        end
        check("rsp_seen", {31'd0, done}, 32'd1);
        if (!done && sb_q.size() > 0) void'(sb_q.pop_front());
        i_mem_ack = 1'b0;
        step();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_op    = 3'd0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        step();
        step();
        check("rst_ready", {31'd0, i_req_ready}, 32'd1);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        check("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
        check("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        i_rst = 1'b0;
        step();

        // we, op, addr, wdata, waits, word, mem, maddr, wstrb, wdata, rdata, err, latency
        do_req(1, 3'd0, 32'h103, 32'h0000_00A5, 0, 32'h0, 1, 32'h100, 4'b1000,
               32'hA5A5_A5A5, 32'h0, 0, 2);
        do_req(0, 3'd0, 32'h102, 32'h0, 3, 32'h00F0_0000, 1, 32'h100, 4'b0000,
               32'h0, 32'hFFFF_FFF0, 0, 5);
        do_req(0, 3'd4, 32'h102, 32'h0, 3, 32'h00F0_0000, 1, 32'h100, 4'b0000,
               32'h0, 32'h0000_00F0, 0, 5);
        do_req(0, 3'd0, 32'h001, 32'h0, 1, 32'h0000_8000, 1, 32'h000, 4'b0000,
               32'h0, 32'hFFFF_FF80, 0, 3);
        do_req(1, 3'd1, 32'h102, 32'h1234_BEEF, 0, 32'h0, 1, 32'h100, 4'b1100,
               32'hBEEF_BEEF, 32'h0, 0, 2);
        do_req(1, 3'd2, 32'h010, 32'hDEAD_BEEF, 2, 32'h0, 1, 32'h010, 4'b1111,
               32'hDEAD_BEEF, 32'h0, 0, 4);
        do_req(0, 3'd1, 32'h002, 32'h0, 0, 32'h8001_7FFF, 1, 32'h000, 4'b0000,
               32'h0, 32'hFFFF_8001, 0, 2);
        do_req(0, 3'd5, 32'h000, 32'h0, 0, 32'h8001_F00D, 1, 32'h000, 4'b0000,
               32'h0, 32'h0000_F00D, 0, 2);
        do_req(0, 3'd2, 32'h008, 32'h0, 0, 32'h1234_5678, 1, 32'h008, 4'b0000,
               32'h0, 32'h1234_5678, 0, 2);
        // No ack within 16 ACCESS cycles, then ack exactly on the 16th.
        do_req(0, 3'd2, 32'h020, 32'h0, 99, 32'h5555_5555, 1, 32'h020, 4'b0000,
               32'h0, 32'h0, 1, 17);
        do_req(0, 3'd2, 32'h020, 32'h0, 15, 32'h5555_5555, 1, 32'h020, 4'b0000,
               32'h0, 32'h5555_5555, 0, 17);
        // Illegal ops and store-unsigned take the immediate error path.
        do_req(0, 3'd3, 32'h040, 32'h0, 0, 32'h0, 0, 32'h0, 4'b0000,
               32'h0, 32'h0, 1, 1);
        do_req(1, 3'd4, 32'h040, 32'h0, 0, 32'h0, 0, 32'h0, 4'b0000,
               32'h0, 32'h0, 1, 1);
        do_req(0, 3'd7, 32'h040, 32'h0, 0, 32'h0, 0, 32'h0, 4'b0000,
               32'h0, 32'h0, 1, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(0, 3'd1, 32'h201, 32'h0, 0, 32'hABCD_1234, 0, 32'h0, 4'b0000,
               32'h0, 32'h0, 1, 1);
`else
        do_req(0, 3'd1, 32'h201, 32'h0, 0, 32'hABCD_1234, 1, 32'h200, 4'b0000,
               32'h0, 32'h0000_1234, 0, 2);
`endif

        // Reset in the second ACCESS cycle, then a stray ack while idle.
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_op    = 3'd2;
        i_req_addr  = 32'h300;
        step();
        i_req_valid = 1'b0;
        step();
        check("rst_mid_mem_req_before", {31'd0, o_mem_req}, 32'd1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check("rst_mid_mem_req", {31'd0, o_mem_req}, 32'd0);
        check("rst_mid_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("rst_mid_ready", {31'd0, i_req_ready}, 32'd1);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hCAFE_F00D;
        step();
        i_mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_ack_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
            check("late_ack_ready", {31'd0, i_req_ready}, 32'd1);
            step();
        end
        do_req(0, 3'd3, 32'h000, 32'h0, 0, 32'h0, 0, 32'h0, 4'b0000,
               32'h0, 32'h0, 1, 1);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
